mdu_iter: RTL
=============

# mdu_iter

Iterative, parametrised multiply/divide unit with HI/LO result registers, used as the successor of the pipeline's fixed-latency HI/LO block. It computes signed/unsigned multiply and divide with a real radix-2 datapath (one bit per cycle) instead of a behavioural operator plus delay counter. It also adds multiply-accumulate/subtract, an abort input for exception flushes, and a configurable operand width. It sits beside the execute-stage ALU; the pipeline stalls on `busy` and reads `hi`/`lo` directly.

## Interface

Parameters:
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4 and even.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  request strobe; `op` is sampled on the edge where this is high.
- `op`  in  4  operation select: MULT 4'b0001, MULTU 4'b0011, DIV 4'b0101, DIVU 4'b0111, MADD 4'b1001, MADDU 4'b1011, MSUB 4'b1101, MSUBU 4'b1111, MTHI 4'b0010, MTLO 4'b0100. All other codes are no-ops.
- `src_a`  in  WIDTH  multiplicand/dividend, or the MTHI/MTLO data.
- `src_b`  in  WIDTH  multiplier/divisor.
- `cancel`  in  1  aborts any in-flight operation.
- `busy`  out  1  high while an arithmetic operation is in flight.
- `hi`  out  WIDTH  HI register, driven directly from a flop.
- `lo`  out  WIDTH  LO register, driven directly from a flop.

## Operation

- **Reset values:** `busy`=0, `hi`=0, `lo`=0, state IDLE, iteration counter 0.
- **States:** IDLE, CALC, FIX.
- **IDLE**, with `op_valid`=1 and `cancel`=0:
  - Arithmetic op: latch the operation, convert signed operands to magnitudes, latch the result signs, clear the counter, go to CALC.
  - MTHI: `hi`←`src_a`, stay in IDLE.
  - MTLO: `lo`←`src_a`, stay in IDLE.
- **CALC:** one iteration per cycle, WIDTH iterations, then go to FIX.
  - Multiply: shift-add over a 2·WIDTH-bit partial product.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
- **FIX:** apply sign correction, write `hi`/`lo`, return to IDLE.
- **Multiply** (MULT/MULTU): {`hi`,`lo`} ← full 2·WIDTH-bit product.
- **Divide** (DIV/DIVU): `lo` ← quotient, `hi` ← remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed MIN ÷ −1: `lo`=MIN, `hi`=0.
  - Divisor 0, either signedness: `hi`=`src_a`, `lo`=all ones. Latency is unchanged.
- **MADD(U)/MSUB(U):** {`hi`,`lo`} ← {`hi`,`lo`} ± product, computed modulo 2^(2·WIDTH).
  - The accumulator is the HI/LO value at the FIX edge.
- **While `busy`=1:** `op_valid` is ignored for every op, including MTHI/MTLO. There is no queueing.
- **`cancel`=1** on any edge in CALC or FIX: go to IDLE, `hi`/`lo` unchanged, `busy` low from the next cycle.
  - In IDLE, `cancel`=1 suppresses acceptance of the same-cycle request, MTHI/MTLO included.
- **Asynchronous `reset` mid-operation:** immediate return to the reset values.

## Timing

- The accept edge is E0. `busy` rises after E0.
- CALC occupies edges E1..E_WIDTH.
- `hi`/`lo` update at edge E_(WIDTH+1); `busy` falls after the same edge.
- `busy` is high for exactly WIDTH+1 cycles (33 for WIDTH=32).
- A new op may be accepted in the first cycle `busy` is low.
- MTHI/MTLO: `hi`/`lo` visible one cycle after the accept edge; `busy` stays 0.
- `hi`/`lo` are pure register outputs. There is no bypass of in-flight results.

## Configuration

- **`MDU_MADD_EN` defined:** MADD, MADDU, MSUB and MSUBU are implemented as described above.
- **`MDU_MADD_EN` undefined:**
  - Those four codes are no-ops: not accepted, `busy` stays 0, HI/LO unchanged.
  - The accumulate/subtract adder is not synthesised.

## Test plan

All scenarios use WIDTH=32.

- **Signed multiply:** MULT, `src_a`=0xFFFFFFFD, `src_b`=7 → `busy` high 33 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- **Unsigned and signed divide:** DIVU 100/7 → `lo`=14, `hi`=2. DIV 0xFFFFFFF9/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIV, `src_a`=0x12345678, `src_b`=0 → after 33 cycles `hi`=0x12345678, `lo`=0xFFFFFFFF.
- **Ignore while busy:**
  - Start MULTU 2×3.
  - At cycle 5 issue MTHI 0xDEAD and at cycle 6 DIVU; both are ignored.
  - Final `hi`=0, `lo`=6.
  - Then MTLO 0x55 in idle → `lo`=0x55 one cycle later.
- **Cancel and reset:**
  - Preload `hi`=1, `lo`=2, start DIV 9/3, assert `cancel` at CALC iteration 10 → `busy`=0 next cycle, `hi`=1, `lo`=2.
  - Repeat with `reset` pulsed mid-CALC → all outputs 0 immediately.
- **Accumulate:** `hi`=0, `lo`=0xFFFFFFFF, MADDU 1×1.
  - With `MDU_MADD_EN` → `hi`=1, `lo`=0; MSUB 1×1 afterwards → `hi`=0, `lo`=0xFFFFFFFF.
  - Without `MDU_MADD_EN` → `busy` stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the execute stage and the iterative multiply/divide unit.
// The master drives the request side; the slave (mdu_iter) drives busy and the HI/LO registers.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, cancel,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// One partial-product / partial-remainder bit per cycle; WIDTH iterations plus a fix-up cycle.
// Optional feature: define MDU_MADD_EN to implement MADD/MADDU/MSUB/MSUBU accumulation into
// HI/LO. Without it those op codes are treated as no-ops and the accumulator adder is absent.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mdu_iter_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               div_q, div_d;       // 1: divide, 0: multiply
  logic               neg_q, neg_d;       // negate product / quotient at fix-up
  logic               rneg_q, rneg_d;     // negate remainder at fix-up
  logic               bzero_q, bzero_d;   // divisor was zero
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;     // {partial product} or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
`ifdef MDU_MADD_EN
  logic               acc_q, acc_d;
  logic               sub_q, sub_d;
`endif

  // Request decode and operand magnitude conversion
  logic             is_arith, is_signed, op_div, op_mthi, op_mtlo;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
`ifdef MDU_MADD_EN
    is_arith = bus.op[0];
`else
    is_arith = bus.op[0] & ~bus.op[3];
`endif
    is_signed = ~bus.op[1];
    op_div    = ~bus.op[3] & bus.op[2];
    op_mthi   = (bus.op == 4'b0010);
    op_mtlo   = (bus.op == 4'b0100);
    a_neg     = is_signed & bus.src_a[WIDTH-1];
    b_neg     = is_signed & bus.src_b[WIDTH-1];
    a_mag     = a_neg ? -bus.src_a : bus.src_a;
    b_mag     = b_neg ? -bus.src_b : bus.src_b;
  end

  // One iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // Remainder stays below the divisor, so bit WIDTH of the difference is set only on borrow.
    div_ok    = ~div_diff[WIDTH];
    div_next  = {div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                 prod_q[WIDTH-2:0], div_ok};
  end

  // Sign correction of the finished result
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo, rem, div_lo, div_hi;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_res;
`endif

  always_comb begin
    mul_res = neg_q ? -prod_q : prod_q;
    quo     = prod_q[WIDTH-1:0];
    rem     = prod_q[2*WIDTH-1:WIDTH];
    // Divide by zero: remainder already equals |src_a| and gets the dividend's sign back.
    div_lo  = bzero_q ? '1 : (neg_q ? -quo : quo);
    div_hi  = rneg_q ? -rem : rem;
`ifdef MDU_MADD_EN
    acc_res = sub_q ? ({hi_q, lo_q} - mul_res) : ({hi_q, lo_q} + mul_res);
`endif
  end

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.op_valid && !bus.cancel) begin
          if (is_arith) begin
            state_d = StCalc;
            cnt_d   = '0;
            div_d   = op_div;
            rneg_d  = a_neg;
            neg_d   = a_neg ^ b_neg;
            bzero_d = (bus.src_b == '0);
`ifdef MDU_MADD_EN
            acc_d   = bus.op[3];
            sub_d   = bus.op[2];
`endif
            if (op_div) begin
              opnd_d = b_mag;
              prod_d = {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd_d = a_mag;
              prod_d = {{WIDTH{1'b0}}, b_mag};
            end
          end else if (op_mthi) begin
            hi_d = bus.src_a;
          end else if (op_mtlo) begin
            lo_d = bus.src_a;
          end
        end
      end
      StCalc: begin
        if (bus.cancel) begin
          state_d = StIdle;
        end else begin
          prod_d = div_q ? div_next : mul_next;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!bus.cancel) begin
          if (div_q) begin
            hi_d = div_hi;
            lo_d = div_lo;
`ifdef MDU_MADD_EN
          end else if (acc_q) begin
            {hi_d, lo_d} = acc_res;
`endif
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
